// File: rtl/stopwatch_dp_pkg.sv
// Shared stopwatch field limits and widths, used by the datapath, the watch datapath and the display mux.
package stopwatch_dp_pkg;

  localparam int MSEC_MAX = 99;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  typedef logic [MSEC_W-1:0] msec_t;
  typedef logic [SEC_W-1:0]  sec_t;
  typedef logic [MIN_W-1:0]  min_t;
  typedef logic [HOUR_W-1:0] hour_t;

  function automatic int tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/stopwatch_dp_if.sv
// Control-unit levels into the stopwatch datapath and elapsed-time fields out to the display stage.
interface stopwatch_dp_if;
  import stopwatch_dp_pkg::*;

  logic  runstop_i;
  logic  clear_i;
  msec_t msec_o;
  sec_t  sec_o;
  min_t  min_o;
  hour_t hour_o;
  logic  tick_o;

  modport master (
    output runstop_i, clear_i,
    input  msec_o, sec_o, min_o, hour_o, tick_o
  );

  modport slave (
    input  runstop_i, clear_i,
    output msec_o, sec_o, min_o, hour_o, tick_o
  );

endinterface

// File: rtl/stopwatch_dp_time_counter.sv
// Mod-(MAX+1) field counter; carry is combinational so a whole cascade rolls over on one edge.
module stopwatch_dp_time_counter #(
  parameter int MAX   = 99,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             tick_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             carry_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             at_max;

  assign at_max = (cnt_q == WIDTH'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = at_max ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign carry_o = tick_i & at_max;

endmodule

// File: rtl/stopwatch_dp.sv
// Stopwatch datapath: centisecond tick divider feeding cascaded msec/sec/min/hour counters.
module stopwatch_dp
  import stopwatch_dp_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 100
) (
  input  logic           clk,
  input  logic           rst,
  stopwatch_dp_if.slave  sw
);

  localparam int DIV = tick_div(CLK_FREQ_HZ, TICK_HZ);
  localparam int DW  = $clog2(DIV);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          div_wrap;
  logic          tick;
  logic          msec_carry, sec_carry, min_carry, hour_carry_unused;

  assign div_wrap = (div_cnt_q == DW'(DIV - 1));
  // clear wins over run, so an illegal run+clear from the control unit never ticks
  assign tick     = sw.runstop_i & ~sw.clear_i & div_wrap;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (sw.clear_i) begin
      div_cnt_d = '0;
    end else if (sw.runstop_i) begin
      div_cnt_d = div_wrap ? '0 : div_cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  stopwatch_dp_time_counter #(.MAX(MSEC_MAX), .WIDTH(MSEC_W)) u_msec (
    .clk(clk), .rst(rst), .clear_i(sw.clear_i), .tick_i(tick),
    .cnt_o(sw.msec_o), .carry_o(msec_carry)
  );

  stopwatch_dp_time_counter #(.MAX(SEC_MAX), .WIDTH(SEC_W)) u_sec (
    .clk(clk), .rst(rst), .clear_i(sw.clear_i), .tick_i(msec_carry),
    .cnt_o(sw.sec_o), .carry_o(sec_carry)
  );

  stopwatch_dp_time_counter #(.MAX(MIN_MAX), .WIDTH(MIN_W)) u_min (
    .clk(clk), .rst(rst), .clear_i(sw.clear_i), .tick_i(sec_carry),
    .cnt_o(sw.min_o), .carry_o(min_carry)
  );

  // hours wrap 23 -> 0 silently; the final carry goes nowhere
  stopwatch_dp_time_counter #(.MAX(HOUR_MAX), .WIDTH(HOUR_W)) u_hour (
    .clk(clk), .rst(rst), .clear_i(sw.clear_i), .tick_i(min_carry),
    .cnt_o(sw.hour_o), .carry_o(hour_carry_unused)
  );

  assign sw.tick_o = tick;

endmodule

// File: tb/tb_stopwatch_dp.sv
// Self-checking bench for stopwatch_dp with DIV = 10: vector table, tick scoreboard and corner sequences.
module tb_stopwatch_dp;
  import stopwatch_dp_pkg::*;

  localparam int CLK_HZ = 1000;
  localparam int TK_HZ  = 100;
  localparam int DIV    = 10;

  typedef struct {
    logic run;
    logic clr;
    int   cycles;
    int   exp_msec;
    int   exp_ticks;
  } vec_t;

  typedef struct {
    int msec;
    int sec;
    int min;
    int hour;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stopwatch_dp_if sw ();

  stopwatch_dp #(.CLK_FREQ_HZ(CLK_HZ), .TICK_HZ(TK_HZ)) dut (
    .clk(clk),
    .rst(rst),
    .sw (sw)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   tick_cnt = 0;
  int   m_cnt    = 0;
  int   m_n      = 0;
  exp_t sb_q[$];
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t fields(input int n);
    exp_t e;
    e.msec = n % 100;
    e.sec  = (n / 100) % 60;
    e.min  = (n / 6000) % 60;
    e.hour = (n / 360000) % 24;
    return e;
  endfunction

  task automatic chk_time(input string name, input int ms, input int s, input int m, input int h);
    chk({name, "_msec"}, 32'(sw.msec_o), ms);
    chk({name, "_sec"},  32'(sw.sec_o),  s);
    chk({name, "_min"},  32'(sw.min_o),  m);
    chk({name, "_hour"}, 32'(sw.hour_o), h);
  endtask

  // drive one cycle; the model predicts the tick and queues the post-edge time
  task automatic step(input logic run, input logic clr);
    logic exp_tick;
    @(negedge clk);
    sw.runstop_i = run;
    sw.clear_i   = clr;
    #1;
    exp_tick = !clr && run && (m_cnt == DIV - 1);
    chk("tick", 32'(sw.tick_o), 32'(exp_tick));
    if (clr) begin
      m_cnt = 0;
      m_n   = 0;
    end else if (run) begin
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_n++;
        sb_q.push_back(fields(m_n));
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
  endtask

  task automatic run_n(input logic run, input logic clr, input int n);
    for (int i = 0; i < n; i++) step(run, clr);
    #2;
  endtask

  initial begin : monitor
    logic t;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      t = sw.tick_o;
      if (t) tick_cnt++;
      @(posedge clk);
      #1;
      if (t) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk_time("sb", e.msec, e.sec, e.min, e.hour);
        end
      end
      chk("msec_range", 32'(sw.msec_o <= 7'd99), 32'd1);
      chk("sec_range",  32'(sw.sec_o  <= 6'd59), 32'd1);
    end
  end

  initial begin : main
    sw.runstop_i = 1'b0;
    sw.clear_i   = 1'b0;

    vecs[0] = '{1'b0, 1'b1, 3,  0, 0};
    vecs[1] = '{1'b1, 1'b0, 30, 3, 3};
    vecs[2] = '{1'b0, 1'b0, 50, 3, 0};
    vecs[3] = '{1'b0, 1'b1, 1,  0, 0};
    vecs[4] = '{1'b1, 1'b0, 4,  0, 0};
    vecs[5] = '{1'b0, 1'b0, 50, 0, 0};
    vecs[6] = '{1'b1, 1'b0, 5,  0, 0};
    vecs[7] = '{1'b1, 1'b0, 1,  1, 1};
    vecs[8] = '{1'b1, 1'b1, 2,  0, 0};
    vecs[9] = '{1'b1, 1'b0, 95, 9, 9};

    #1;
    chk_time("reset", 0, 0, 0, 0);
    chk("reset_tick", 32'(sw.tick_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      tick_cnt = 0;
      run_n(vecs[v].run, vecs[v].clr, vecs[v].cycles);
      chk($sformatf("vec%0d_msec", v), 32'(sw.msec_o), vecs[v].exp_msec);
      chk($sformatf("vec%0d_ticks", v), tick_cnt, vecs[v].exp_ticks);
      chk($sformatf("vec%0d_sec", v), 32'(sw.sec_o), 32'd0);
    end

    // async reset mid-run clears everything before the next edge
    run_n(1'b1, 1'b0, 13);
    #1;
    rst = 1'b1;
    #1;
    chk_time("async_rst", 0, 0, 0, 0);
    chk("async_rst_tick", 32'(sw.tick_o), 32'd0);
    @(negedge clk);
    sw.runstop_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0;
    m_n   = 0;
    sb_q.delete();
    run_n(1'b0, 1'b0, 20);
    chk_time("post_rst_hold", 0, 0, 0, 0);
    tick_cnt = 0;
    run_n(1'b1, 1'b0, 10);
    chk_time("post_rst_run", 1, 0, 0, 0);
    chk("post_rst_ticks", tick_cnt, 32'd1);

    // clear while running at 00:00:12.34, then restart from divider 0
    run_n(1'b0, 1'b1, 1);
    run_n(1'b1, 1'b0, 12340);
    chk_time("at_12_34", 34, 12, 0, 0);
    tick_cnt = 0;
    run_n(1'b1, 1'b1, 1);
    chk_time("clear_edge", 0, 0, 0, 0);
    run_n(1'b1, 1'b1, 25);
    chk("clear_no_tick", tick_cnt, 32'd0);
    run_n(1'b1, 1'b0, 9);
    chk_time("restart_9", 0, 0, 0, 0);
    run_n(1'b1, 1'b0, 1);
    chk_time("restart_10", 1, 0, 0, 0);

    // 00:00:59.99 -> 00:01:00.00 on one edge
    run_n(1'b0, 1'b1, 1);
    run_n(1'b1, 1'b0, 59990);
    chk_time("at_59_99", 99, 59, 0, 0);
    run_n(1'b1, 1'b0, 10);
    chk_time("min_roll", 0, 0, 1, 0);

    // preload 23:59:59.99 -> 00:00:00.00 on one edge
    run_n(1'b0, 1'b1, 1);
    @(negedge clk);
    sw.clear_i   = 1'b0;
    sw.runstop_i = 1'b0;
    force dut.u_msec.cnt_q = 7'd99;
    force dut.u_sec.cnt_q  = 6'd59;
    force dut.u_min.cnt_q  = 6'd59;
    force dut.u_hour.cnt_q = 5'd23;
    #1;
    release dut.u_msec.cnt_q;
    release dut.u_sec.cnt_q;
    release dut.u_min.cnt_q;
    release dut.u_hour.cnt_q;
    #1;
    chk_time("preload", 99, 59, 59, 23);
    m_cnt = 0;
    m_n   = 8639999;
    run_n(1'b1, 1'b0, 9);
    chk_time("pre_wrap", 99, 59, 59, 23);
    run_n(1'b1, 1'b0, 1);
    chk_time("day_wrap", 0, 0, 0, 0);
    run_n(1'b1, 1'b0, 10);
    chk_time("after_wrap", 1, 0, 0, 0);

    run_n(1'b0, 1'b0, 3);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
